combination_wb_master: RTL



---
 rtl/combination_wb_master_if.sv | 44 ++++
 rtl/combination_wb_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/combination_wb_master_if.sv
// combination_interface: link between the host-side master and the engine.
// Master drives config, LUT and reset requests; the slave returns results.
interface combination_interface #(
  parameter int TIME_WIDTH        = 64,
  parameter int CHANNELS_IN_WIDTH = 6,
  parameter int CHANNELS          = 16,
  parameter int ACC_WIDTH         = 32
);
  logic [TIME_WIDTH-1:0]        window;
  logic [CHANNELS_IN_WIDTH-1:0] filter_min;
  logic [CHANNELS_IN_WIDTH-1:0] filter_max;
  logic                         capture_enable;
  logic                         start_reading;
  logic [1:0]                   select_comb_fifo;
  logic                         ready_o;
  logic                         overflow;
  logic [CHANNELS_IN_WIDTH-1:0] lut_addr;
  logic [CHANNELS-1:0]          lut_dat_i;
  logic [CHANNELS-1:0]          lut_dat_o;
  logic [1:0]                   lut_WrRd;
  logic                         lut_ack;
  logic                         reset_comb;
  logic                         reset_comb_done;
  logic                         ready_i;
  logic                         comb_out_vd;
  logic [CHANNELS-1:0]          comb_value;
  logic [ACC_WIDTH-1:0]         comb_count;

  modport master (
    output window, filter_min, filter_max, capture_enable,
    output start_reading, select_comb_fifo, lut_addr, lut_dat_i,
    output lut_WrRd, reset_comb, ready_i,
    input  ready_o, overflow, lut_dat_o, lut_ack, reset_comb_done,
    input  comb_out_vd, comb_value, comb_count
  );

  modport slave (
    input  window, filter_min, filter_max, capture_enable,
    input  start_reading, select_comb_fifo, lut_addr, lut_dat_i,
    input  lut_WrRd, reset_comb, ready_i,
    output ready_o, overflow, lut_dat_o, lut_ack, reset_comb_done,
    output comb_out_vd, comb_value, comb_count
  );
endinterface

// File: rtl/combination_wb_master.sv
// combination_wb_master: Wishbone register front-end for the combination engine.
// Define COMB_WB_TIMEOUT_EN to abort stuck LUT/reset handshakes.
module combination_wb_master #(
  parameter int TIME_WIDTH        = 64,
  parameter int CHANNELS_IN_WIDTH = 6,
  parameter int CHANNELS          = 16,
  parameter int ACC_WIDTH         = 32,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [7:0]  wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  combination_interface.master comb
);
  localparam int AW = CHANNELS_IN_WIDTH;
  localparam logic [5:0] A_STAT = 6'h00;
  localparam logic [5:0] A_CTRL = 6'h01;
  localparam logic [5:0] A_WLO  = 6'h02;
  localparam logic [5:0] A_WHI  = 6'h03;
  localparam logic [5:0] A_FILT = 6'h04;
  localparam logic [5:0] A_LADR = 6'h05;
  localparam logic [5:0] A_LDAT = 6'h06;
  localparam logic [5:0] A_LCMD = 6'h07;
  localparam logic [5:0] A_RVAL = 6'h08;
  localparam logic [5:0] A_RCNT = 6'h09;

  typedef enum logic {L_IDLE, L_REQ} lut_st_t;
  typedef enum logic {R_IDLE, R_RST} rst_st_t;

  lut_st_t lut_st, lut_st_n;
  rst_st_t rst_st, rst_st_n;

  logic [5:0]            a;
  logic                  req, wr, pop, clr;
  logic                  wr_ctrl, wr_cmd;
  logic                  lut_busy, rst_busy;
  logic                  lut_tmo, rst_tmo, tmo_set;
  logic                  capture, rv_n, ready_n;
  logic [31:0]           rdata;
  logic [63:0]           win64;
  logic                  unused_adr;

  logic [TIME_WIDTH-1:0] window_q;
  logic [31:0]           win_lo_q;
  logic [AW-1:0]         fmin_q, fmax_q, ladr_q;
  logic                  cap_q, start_q, lut_wr_q;
  logic [1:0]            sel_q;
  logic [CHANNELS-1:0]   ldat_q, lrd_q, rval_q;
  logic [ACC_WIDTH-1:0]  rcnt_q;
  logic                  ovf_q, tmo_q, rv_q, ready_q;

  assign a          = wb_adr[7:2];
  assign unused_adr = ^wb_adr[1:0];
  assign req        = wb_cyc & wb_stb;
  assign wr         = req & wb_we & wb_ack;
  assign pop        = req & ~wb_we & wb_ack & (a == A_RCNT);
  assign wr_ctrl    = wr & (a == A_CTRL);
  assign wr_cmd     = wr & (a == A_LCMD);
  assign clr        = wr_ctrl & wb_dat_i[8];
  assign lut_busy   = lut_st == L_REQ;
  assign rst_busy   = rst_st == R_RST;
  assign capture    = comb.comb_out_vd & ready_q;
  assign win64      = 64'(window_q);

`ifdef COMB_WB_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] lut_cnt, rst_cnt;

  // Dwell counters for each pending handshake, cleared while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      lut_cnt <= lut_busy ? lut_cnt + 32'd1 : '0;
      rst_cnt <= rst_busy ? rst_cnt + 32'd1 : '0;
    end
  end

  assign lut_tmo = lut_busy & (lut_cnt == TMO_LAST);
  assign rst_tmo = rst_busy & (rst_cnt == TMO_LAST);
  assign tmo_set = (lut_tmo & ~comb.lut_ack)
                 | (rst_tmo & ~comb.reset_comb_done);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign lut_tmo    = 1'b0;
  assign rst_tmo    = 1'b0;
  assign tmo_set    = 1'b0;
`endif

  // State registers for both handshake FSMs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_st <= L_IDLE;
      rst_st <= R_IDLE;
    end else begin
      lut_st <= lut_st_n;
      rst_st <= rst_st_n;
    end
  end

  // LUT FSM: one request outstanding; new commands ignored while busy.
  always_comb begin
    lut_st_n = lut_st;
    unique case (lut_st)
      L_IDLE: if (wr_cmd && (wb_dat_i[0] || wb_dat_i[1])) lut_st_n = L_REQ;
      L_REQ:  if (comb.lut_ack || lut_tmo) lut_st_n = L_IDLE;
    endcase
  end

  // Reset FSM: hold reset_comb until the engine reports done.
  always_comb begin
    rst_st_n = rst_st;
    unique case (rst_st)
      R_IDLE: if (wr_ctrl && wb_dat_i[2]) rst_st_n = R_RST;
      R_RST:  if (comb.reset_comb_done || rst_tmo) rst_st_n = R_IDLE;
    endcase
  end

  // Holding register bookkeeping: flush beats capture beats pop.
  always_comb begin
    rv_n = rv_q;
    if (rst_busy)     rv_n = 1'b0;
    else if (capture) rv_n = 1'b1;
    else if (pop)     rv_n = 1'b0;
    ready_n = ~rv_n & (rst_st_n != R_RST);
  end

  // Register file writes, sticky flags and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      win_lo_q <= '0;
      fmin_q   <= '0;
      fmax_q   <= '0;
      cap_q    <= 1'b0;
      start_q  <= 1'b0;
      sel_q    <= '0;
      ladr_q   <= '0;
      ldat_q   <= '0;
      lrd_q    <= '0;
      lut_wr_q <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      rv_q     <= 1'b0;
      ready_q  <= 1'b0;
      rval_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      start_q <= wr_ctrl & wb_dat_i[1];
      if (wr && a == A_WLO) win_lo_q <= wb_dat_i;
      if (wr && a == A_WHI) window_q <= TIME_WIDTH'({wb_dat_i, win_lo_q});
      if (wr && a == A_FILT) begin
        fmin_q <= AW'(wb_dat_i[7:0]);
        fmax_q <= AW'(wb_dat_i[15:8]);
      end
      if (rst_busy)     cap_q <= 1'b0;
      else if (wr_ctrl) cap_q <= wb_dat_i[0];
      if (wr_ctrl) sel_q <= wb_dat_i[5:4];
      if (wr && a == A_LADR && !lut_busy) ladr_q <= AW'(wb_dat_i);
      if (wr && a == A_LDAT && !lut_busy) ldat_q <= CHANNELS'(wb_dat_i);
      if (!lut_busy && lut_st_n == L_REQ) lut_wr_q <= wb_dat_i[0];
      if (lut_busy && comb.lut_ack && !lut_wr_q) lrd_q <= comb.lut_dat_o;
      ovf_q   <= comb.overflow | (ovf_q & ~clr);
      tmo_q   <= tmo_set | (tmo_q & ~clr);
      rv_q    <= rv_n;
      ready_q <= ready_n;
      if (capture) begin
        rval_q <= comb.comb_value;
        rcnt_q <= comb.comb_count;
      end
    end
  end

  // Read data mux; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (a)
      A_STAT: rdata = {26'b0, tmo_q, rv_q, lut_busy, rst_busy,
                       ovf_q, comb.ready_o};
      A_CTRL: rdata = {26'b0, sel_q, 3'b0, cap_q};
      A_WLO:  rdata = win64[31:0];
      A_WHI:  rdata = win64[63:32];
      A_FILT: rdata = {16'b0, 8'(fmax_q), 8'(fmin_q)};
      A_LADR: rdata = 32'(ladr_q);
      A_LDAT: rdata = 32'(lrd_q);
      A_RVAL: rdata = 32'(rval_q);
      A_RCNT: rdata = 32'(rcnt_q);
      default: rdata = '0;
    endcase
  end

  // Single-cycle ack one clock after the request; data rides with ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack   <= req & ~wb_ack;
      wb_dat_o <= (req & ~wb_ack) ? rdata : '0;
    end
  end

  assign comb.window           = window_q;
  assign comb.filter_min       = fmin_q;
  assign comb.filter_max       = fmax_q;
  assign comb.capture_enable   = cap_q & ~rst_busy;
  assign comb.start_reading    = start_q;
  assign comb.select_comb_fifo = sel_q;
  assign comb.lut_addr         = ladr_q;
  assign comb.lut_dat_i        = ldat_q;
  assign comb.lut_WrRd         = lut_busy ? (lut_wr_q ? 2'b10 : 2'b01)
                                          : 2'b00;
  assign comb.reset_comb       = rst_busy;
  assign comb.ready_i          = ready_q;
endmodule
